// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and pprot bit positions
package apb_pkg;

    // Bus phase, shared by requester and completer.
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    // Bit positions inside pprot.
    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - wait-state watchdog counter for the APB requester
//
// Ports:
//   i_clk     clock
//   i_resetn  synchronous active-low reset
//   i_clear   zero the count (asserted in the cycle before ACCESS)
//   i_enable  one wait cycle observed (ACCESS with pready low)
//   o_expire  this wait cycle is the TIMEOUT_CYCLES-th in a row
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] r_count;

            // The count holds the wait cycles already seen, so expiry fires on
            // the wait cycle that would bring it to TIMEOUT_CYCLES.
            always_ff @(posedge i_clk) begin
                if (!i_resetn || i_clear) begin
                    r_count <= '0;
                end else if (i_enable && !o_expire) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign o_expire = i_enable && (r_count == LAST);
        end else begin : g_off
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB5 requester: command port to SETUP/ACCESS bus sequence
//
// Ports:
//   pclk, preset_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/wdata/strb/prot  command payload
//   rsp_valid/rdata/slverr/timeout  one-cycle response pulse
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   registered APB outputs
//   prdata/pready/pslverr           completer response
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    apb_state_e              r_state;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [DATA_WIDTH/8-1:0] r_pstrb;
    logic [2:0]              r_pprot;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_slverr;
    logic                    r_rsp_timeout;

    logic w_complete;
    logic w_cmd_ready;
    logic w_handshake;
    logic w_expire;

    // Ready in IDLE, and also in the completing ACCESS cycle so a following
    // command can go straight to SETUP without an IDLE gap.
    assign w_complete  = (r_state == APB_ACCESS) && pready;
    assign w_cmd_ready = preset_n && ((r_state == APB_IDLE) || w_complete);
    assign w_handshake = cmd_valid && w_cmd_ready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk    (pclk),
        .i_resetn (preset_n),
        .i_clear  (r_state == APB_SETUP),
        .i_enable ((r_state == APB_ACCESS) && !pready),
        .o_expire (w_expire)
    );

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state       <= APB_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;

            case (r_state)
                APB_IDLE: begin
                end
                APB_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_slverr  <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= APB_IDLE;
                    end else if (w_expire) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= APB_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= APB_IDLE;
                end
            endcase

            // A new command overrides the IDLE fall-back of a completing
            // transfer, keeping psel high into the next SETUP.
            if (w_handshake) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= cmd_write;
                r_paddr   <= cmd_addr;
                r_pprot   <= cmd_prot;
                r_pstrb   <= cmd_write ? cmd_strb : '0;
                if (cmd_write) begin
                    r_pwdata <= cmd_wdata;
                end
                r_state   <= APB_SETUP;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign pprot       = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester
module tb_apb_requester;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb_requester #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    endtask

    task automatic test_reset;
        preset_n = 1'b0;
        drive_cmd(1'b1, 32'h204, 32'h1111_2222, 4'hF, 3'b111);
        repeat (3) @(negedge pclk);
        #1;
        n_cmp++; if ({psel, penable, pwrite} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b exp 000", {psel, penable, pwrite}); end
        n_cmp++; if (paddr !== 32'h0) begin n_bad++; $display("FAIL reset_paddr: got %h exp 0", paddr); end
        n_cmp++; if (pwdata !== 32'h0) begin n_bad++; $display("FAIL reset_pwdata: got %h exp 0", pwdata); end
        n_cmp++; if ({pstrb, pprot} !== 7'h0) begin n_bad++; $display("FAIL reset_strb_prot: got %h exp 0", {pstrb, pprot}); end
        n_cmp++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_rsp: got %b exp 000", {rsp_valid, rsp_slverr, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
        cmd_valid = 1'b0;
        preset_n  = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_cmd_ready: got %b exp 1", cmd_ready); end
        @(negedge pclk); #1;
        n_cmp++; if ({psel, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL release_idle: got %b exp 01", {psel, cmd_ready}); end
    endtask

    task automatic test_zero_wait_write;
        @(negedge pclk);
        drive_cmd(1'b1, 32'h204, 32'hDEAD_BEEF, 4'hF, 3'b010);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL zw_ready: got %b exp 1", cmd_ready); end
        @(negedge pclk);
        cmd_valid = 1'b0; #1;
        n_cmp++; if ({psel, penable, pwrite} !== 3'b101) begin n_bad++; $display("FAIL zw_setup_ctrl: got %b exp 101", {psel, penable, pwrite}); end
        n_cmp++; if ({paddr, pwdata, pstrb, pprot} !== {32'h204, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin n_bad++; $display("FAIL zw_setup_bus: got %h %h %h %h", paddr, pwdata, pstrb, pprot); end
        @(negedge pclk);
        pready = 1'b1; pslverr = 1'b0; #1;
        n_cmp++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1101) begin n_bad++; $display("FAIL zw_access: got %b exp 1101", {psel, penable, rsp_valid, cmd_ready}); end
        @(negedge pclk);
        pready = 1'b0; #1;
        n_cmp++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b100) begin n_bad++; $display("FAIL zw_rsp: got %b exp 100", {rsp_valid, rsp_slverr, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL zw_rdata: got %h exp 0", rsp_rdata); end
        n_cmp++; if ({psel, penable} !== 2'b00) begin n_bad++; $display("FAIL zw_idle: got %b exp 00", {psel, penable}); end
        @(negedge pclk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL zw_pulse: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_read_waits;
        @(negedge pclk);
        drive_cmd(1'b0, 32'h204, 32'h1234_5678, 4'hF, 3'b000);
        @(negedge pclk);
        cmd_valid = 1'b0; #1;
        n_cmp++; if ({pwdata, pstrb, pwrite} !== {32'hDEAD_BEEF, 4'h0, 1'b0}) begin n_bad++; $display("FAIL rd_setup: got %h %h %b", pwdata, pstrb, pwrite); end
        n_cmp++; if ({paddr, psel, penable} !== {32'h204, 2'b10}) begin n_bad++; $display("FAIL rd_setup_addr: got %h %b%b", paddr, psel, penable); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            pready = (k == 4); prdata = (k == 4) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD; #1;
            n_cmp++; if ({paddr, pstrb, psel, penable, rsp_valid} !== {32'h204, 4'h0, 3'b110}) begin n_bad++; $display("FAIL rd_access_%0d: got %h %h %b%b%b", k, paddr, pstrb, psel, penable, rsp_valid); end
        end
        @(negedge pclk);
        pready = 1'b0; #1;
        n_cmp++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b100) begin n_bad++; $display("FAIL rd_rsp: got %b exp 100", {rsp_valid, rsp_slverr, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata: got %h exp deadbeef", rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        @(negedge pclk);
        drive_cmd(1'b1, 32'h200, 32'hCAFE_F00D, 4'h3, 3'b001);
        @(negedge pclk);
        drive_cmd(1'b0, 32'h200, 32'h0, 4'hF, 3'b000); #1;
        n_cmp++; if ({psel, penable, pwrite, cmd_ready} !== 4'b1010) begin n_bad++; $display("FAIL b2b_setup1: got %b exp 1010", {psel, penable, pwrite, cmd_ready}); end
        @(negedge pclk);
        pready = 1'b1; #1;
        n_cmp++; if ({psel, penable, cmd_ready} !== 3'b111) begin n_bad++; $display("FAIL b2b_access1: got %b exp 111", {psel, penable, cmd_ready}); end
        @(negedge pclk);
        pready = 1'b0; cmd_valid = 1'b0; #1;
        n_cmp++; if ({psel, penable, pwrite, pstrb} !== {3'b100, 4'h0}) begin n_bad++; $display("FAIL b2b_setup2: got %b%b%b %h", psel, penable, pwrite, pstrb); end
        n_cmp++; if ({paddr, pwdata} !== {32'h200, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL b2b_setup2_bus: got %h %h", paddr, pwdata); end
        n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL b2b_rsp1: got %b %h exp 1 0", rsp_valid, rsp_rdata); end
        @(negedge pclk);
        pready = 1'b1; prdata = 32'hA5A5_5A5A; #1;
        n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL b2b_access2: got %b exp 11", {psel, penable}); end
        @(negedge pclk);
        pready = 1'b0; #1;
        n_cmp++; if ({rsp_valid, rsp_rdata, psel} !== {1'b1, 32'hA5A5_5A5A, 1'b0}) begin n_bad++; $display("FAIL b2b_rsp2: got %b %h %b", rsp_valid, rsp_rdata, psel); end
    endtask

    task automatic test_error;
        @(negedge pclk);
        drive_cmd(1'b0, 32'h3, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        cmd_valid = 1'b0; #1;
        n_cmp++; if (paddr !== 32'h3) begin n_bad++; $display("FAIL err_paddr: got %h exp 3", paddr); end
        @(negedge pclk);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h0;
        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0; #1;
        n_cmp++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b110) begin n_bad++; $display("FAIL err_rsp: got %b exp 110", {rsp_valid, rsp_slverr, rsp_timeout}); end
    endtask

    task automatic test_watchdog;
        @(negedge pclk);
        drive_cmd(1'b0, 32'h100, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            pready = 1'b0;
            if (k == 4) drive_cmd(1'b1, 32'h300, 32'h7777_8888, 4'hF, 3'b000);
            #1;
            n_cmp++; if ({psel, penable, cmd_ready} !== 3'b110) begin n_bad++; $display("FAIL wd_access_%0d: got %b exp 110", k, {psel, penable, cmd_ready}); end
        end
        @(negedge pclk); #1;
        n_cmp++; if ({psel, penable} !== 2'b00) begin n_bad++; $display("FAIL wd_drop: got %b exp 00", {psel, penable}); end
        n_cmp++; if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata} !== {3'b111, 32'h0}) begin n_bad++; $display("FAIL wd_rsp: got %b%b%b %h", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wd_ready_after: got %b exp 1", cmd_ready); end
        @(negedge pclk);
        cmd_valid = 1'b0; #1;
        n_cmp++; if ({psel, penable, paddr} !== {2'b10, 32'h300}) begin n_bad++; $display("FAIL wd_next_setup: got %b%b %h", psel, penable, paddr); end
        @(negedge pclk);
        pready = 1'b1;
        @(negedge pclk);
        pready = 1'b0; #1;
        n_cmp++; if ({rsp_valid, rsp_timeout} !== 2'b10) begin n_bad++; $display("FAIL wd_next_rsp: got %b exp 10", {rsp_valid, rsp_timeout}); end
    endtask

    task automatic test_reset_mid;
        @(negedge pclk);
        drive_cmd(1'b1, 32'h44, 32'h5555_AAAA, 4'hF, 3'b000);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        pready = 1'b1; preset_n = 1'b0; #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b exp 0", cmd_ready); end
        @(negedge pclk);
        pready = 1'b0; preset_n = 1'b1; #1;
        n_cmp++; if ({psel, penable, rsp_valid, paddr} !== {3'b000, 32'h0}) begin n_bad++; $display("FAIL mid_abort: got %b%b%b %h", psel, penable, rsp_valid, paddr); end
        @(negedge pclk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp: got %b exp 0", rsp_valid); end
    endtask

    initial begin
        preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        test_reset;
        test_zero_wait_write;
        test_read_waits;
        test_back_to_back;
        test_error;
        test_watchdog;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
